// File: rtl/memo_pkg.sv
// Shared types and codes for the memory-game turn controller.
package memo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TURN,
        SHOW,
        SWITCH,
        GAME_OVER
    } state_e;

    localparam logic [1:0] TURN_NONE = 2'b00;
    localparam logic [1:0] TURN_DONE = 2'b01;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_J1   = 2'b01;
    localparam logic [1:0] WIN_J2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    // Winner code from the two player scores; equal scores are a tie.
    function automatic logic [1:0] pick_winner(input logic [7:0] s1, input logic [7:0] s2);
        if (s1 > s2) begin
            return WIN_J1;
        end else if (s2 > s1) begin
            return WIN_J2;
        end
        return WIN_TIE;
    endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Bundle between the turn controller (slave side) and the board/compare logic (master side).
interface game_turn_ctrl_if;

    logic       start;
    logic [1:0] turn_done;
    logic       match;
    logic [7:0] score_j1;
    logic [7:0] score_j2;

    logic       player;
    logic       busy;
    logic       hide_req;
    logic [7:0] pairs_found;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, turn_done, match, score_j1, score_j2,
        input  player, busy, hide_req, pairs_found, game_over, winner
    );

    modport slave (
        input  start, turn_done, match, score_j1, score_j2,
        output player, busy, hide_req, pairs_found, game_over, winner
    );

endinterface

// File: rtl/delay_cnt.sv
// Loadable up-counter: counts 0..LIMIT-1 while enabled and emits a registered
// one-cycle pulse on done in the cycle after the count reaches LIMIT-1.
module delay_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    // Wrapping at LAST keeps done a single-cycle pulse even if en stays high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            done <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for a two-player memory game: pair counting, mismatch hide delay,
// player hand-over and winner capture. Define TURN_TIMEOUT_EN for a per-turn time limit.
module game_turn_ctrl
    import memo_pkg::*;
#(
    parameter int unsigned NUM_PAIRS      = 8,
    parameter int unsigned HIDE_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic              clk,
    input  logic              rst,
    game_turn_ctrl_if.slave   bus
);

    localparam logic [7:0] PAIRS_MAX = 8'(NUM_PAIRS);

    if (NUM_PAIRS < 1 || NUM_PAIRS > 255) begin : g_bad_pairs
        $error("NUM_PAIRS must be in 1..255");
    end
    if (HIDE_CYCLES < 1) begin : g_bad_hide
        $error("HIDE_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e     state;
    logic       turn_ev_c;
    logic [1:0] winner_c;
    logic       hide_load_c;
    logic       hide_en_c;
    logic       hide_done;
    logic       timeout_done;

    assign turn_ev_c   = (bus.turn_done == TURN_DONE);
    assign winner_c    = pick_winner(bus.score_j1, bus.score_j2);
    assign hide_load_c = (state != SHOW);
    assign hide_en_c   = (state == SHOW);

    delay_cnt #(
        .LIMIT (HIDE_CYCLES)
    ) u_hide_timer (
        .clk  (clk),
        .rst  (rst),
        .load (hide_load_c),
        .en   (hide_en_c),
        .done (hide_done)
    );

`ifdef TURN_TIMEOUT_EN
    logic turn_load_c;
    logic turn_en_c;

    assign turn_load_c = (state != WAIT_TURN) || turn_ev_c;
    assign turn_en_c   = (state == WAIT_TURN);

    // The registered pulse lands one cycle after the counter's last value, so the
    // limit is pulled in by one: done is visible in the timer's (TIMEOUT_CYCLES-1)th cycle.
    delay_cnt #(
        .LIMIT (TIMEOUT_CYCLES - 1)
    ) u_turn_timer (
        .clk  (clk),
        .rst  (rst),
        .load (turn_load_c),
        .en   (turn_en_c),
        .done (timeout_done)
    );
`else
    assign timeout_done = 1'b0;
`endif

    // Game sequencing; every output is a flop updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bus.player      <= 1'b0;
            bus.busy        <= 1'b1;
            bus.hide_req    <= 1'b0;
            bus.pairs_found <= '0;
            bus.game_over   <= 1'b0;
            bus.winner      <= WIN_NONE;
        end else begin
            bus.hide_req <= 1'b0;
            case (state)
                IDLE, GAME_OVER: begin
                    if (bus.start) begin
                        state           <= WAIT_TURN;
                        bus.player      <= 1'b0;
                        bus.busy        <= 1'b0;
                        bus.pairs_found <= '0;
                        bus.game_over   <= 1'b0;
                        bus.winner      <= WIN_NONE;
                    end
                end
                WAIT_TURN: begin
                    // A turn event outranks a timeout expiring in the same cycle.
                    if (turn_ev_c) begin
                        if (bus.match) begin
                            if (bus.pairs_found != PAIRS_MAX) begin
                                bus.pairs_found <= bus.pairs_found + 8'd1;
                            end
                            if ((bus.pairs_found + 8'd1) >= PAIRS_MAX) begin
                                state         <= GAME_OVER;
                                bus.busy      <= 1'b1;
                                bus.game_over <= 1'b1;
                                bus.winner    <= winner_c;
                            end
                        end else begin
                            state    <= SHOW;
                            bus.busy <= 1'b1;
                        end
                    end else if (timeout_done) begin
                        state    <= SWITCH;
                        bus.busy <= 1'b1;
                    end
                end
                SHOW: begin
                    if (hide_done) begin
                        bus.hide_req <= 1'b1;
                        state        <= SWITCH;
                    end
                end
                SWITCH: begin
                    bus.player <= ~bus.player;
                    bus.busy   <= 1'b0;
                    state      <= WAIT_TURN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl: vector table for whole games plus hand-written
// sequences for hide latency, events during SHOW, reset mid-SHOW and the turn timer.
module tb_game_turn_ctrl;
    import memo_pkg::*;

    localparam int unsigned NP = 8;
    localparam int unsigned HC = 4;
    localparam int unsigned TC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    game_turn_ctrl_if bus ();

    game_turn_ctrl #(
        .NUM_PAIRS      (NP),
        .HIDE_CYCLES    (HC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] td;
        logic       match;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       player;
        logic       busy;
        logic [7:0] pairs;
        logic       go;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input int st, input int td, input int m, input int s1, input int s2,
                                input int p, input int b, input int pr, input int go, input int w);
        vec_t v;
        v.start  = 1'(st);
        v.td     = 2'(td);
        v.match  = 1'(m);
        v.s1     = 8'(s1);
        v.s2     = 8'(s2);
        v.player = 1'(p);
        v.busy   = 1'(b);
        v.pairs  = 8'(pr);
        v.go     = 1'(go);
        v.win    = 2'(w);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int p, input int b, input int h,
                           input int pr, input int go, input int w);
        chk({tag, " player"},      int'(bus.player),      p);
        chk({tag, " busy"},        int'(bus.busy),        b);
        chk({tag, " hide_req"},    int'(bus.hide_req),    h);
        chk({tag, " pairs_found"}, int'(bus.pairs_found), pr);
        chk({tag, " game_over"},   int'(bus.game_over),   go);
        chk({tag, " winner"},      int'(bus.winner),      w);
    endtask

    task automatic drive(input logic st, input logic [1:0] td, input logic m);
        bus.start     = st;
        bus.turn_done = td;
        bus.match     = m;
    endtask

    initial begin
        drive(1'b0, TURN_NONE, 1'b0);
        bus.score_j1 = 8'd0;
        bus.score_j2 = 8'd0;

        // Game 1: ignored codes, saturation in GAME_OVER, J2 wins 3/5.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 2, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 3, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 2; i <= 7; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, i, 0, 0));
        vecs.push_back(mk(0, 1, 1, 3, 5, 0, 1, 8, 1, 2));
        vecs.push_back(mk(0, 1, 1, 3, 5, 0, 1, 8, 1, 2));
        vecs.push_back(mk(0, 0, 0, 9, 0, 0, 1, 8, 1, 2));
        // Game 2: tie 4/4.
        vecs.push_back(mk(1, 0, 0, 4, 4, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 7; i++) vecs.push_back(mk(0, 1, 1, 4, 4, 0, 0, i, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4, 4, 0, 1, 8, 1, 3));
        // Game 3: J1 wins 7/2.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 7; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, i, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 2, 0, 1, 8, 1, 1));

        step();
        step();
        rst = 1'b0;
        chk_all("reset", 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].td, vecs[i].match);
            bus.score_j1 = vecs[i].s1;
            bus.score_j2 = vecs[i].s2;
            step();
            chk_all($sformatf("vec%0d", i), int'(vecs[i].player), int'(vecs[i].busy), 0,
                    int'(vecs[i].pairs), int'(vecs[i].go), int'(vecs[i].win));
        end
        drive(1'b0, TURN_NONE, 1'b0);

        // Mismatch latency: hide_req on cycle HC+1, player toggles on HC+2.
        drive(1'b1, TURN_NONE, 1'b0);
        step();
        drive(1'b1, TURN_DONE, 1'b0);
        bus.start = 1'b0;
        step();
        drive(1'b0, TURN_NONE, 1'b0);
        chk("lat busy c0", int'(bus.busy), 1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("lat hide c%0d", k), int'(bus.hide_req), (k == 5) ? 1 : 0);
            chk($sformatf("lat player c%0d", k), int'(bus.player), (k >= 6) ? 1 : 0);
        end
        chk("lat busy c6", int'(bus.busy), 0);

        // Turn events during SHOW are ignored; a single toggle back to J1.
        drive(1'b0, TURN_DONE, 1'b0);
        step();
        for (int k = 1; k <= 9; k++) begin
            if (k == 2)      drive(1'b0, TURN_DONE, 1'b1);
            else if (k == 3) drive(1'b0, TURN_DONE, 1'b0);
            else             drive(1'b0, TURN_NONE, 1'b0);
            step();
            chk($sformatf("show pairs c%0d", k), int'(bus.pairs_found), 0);
            chk($sformatf("show player c%0d", k), int'(bus.player), (k < 6) ? 1 : 0);
        end

        // Reset two cycles into SHOW drops the pending hide_req.
        drive(1'b0, TURN_DONE, 1'b0);
        step();
        drive(1'b0, TURN_NONE, 1'b0);
        for (int k = 0; k < 6; k++) step();
        drive(1'b0, TURN_DONE, 1'b1);
        step();
        drive(1'b0, TURN_DONE, 1'b0);
        step();
        drive(1'b0, TURN_NONE, 1'b0);
        step();
        step();
        chk("pre-rst player", int'(bus.player), 1);
        chk("pre-rst pairs", int'(bus.pairs_found), 1);
        rst = 1'b1;
        #1;
        chk_all("async rst", 0, 1, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_all($sformatf("post-rst c%0d", k), 0, 1, 0, 0, 0, 0);
        end

        // Idle WAIT_TURN: turn timer hands over every TC+1 cycles when built in.
        drive(1'b1, TURN_NONE, 1'b0);
        step();
        drive(1'b0, TURN_NONE, 1'b0);
        for (int k = 1; k <= 25; k++) begin
            int ep;
            int eb;
`ifdef TURN_TIMEOUT_EN
            ep = (k >= 11 && k < 22) ? 1 : 0;
            eb = (k == 10 || k == 21) ? 1 : 0;
`else
            ep = 0;
            eb = 0;
`endif
            step();
            chk($sformatf("idle player c%0d", k), int'(bus.player), ep);
            chk($sformatf("idle busy c%0d", k), int'(bus.busy), eb);
            chk($sformatf("idle hide c%0d", k), int'(bus.hide_req), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_turn_ctrl.md
GAME_TURN_CTRL -- requirements
Module: game_turn_ctrl

Interface
REQ-001 Parameter NUM_PAIRS, default 8: pairs on the board; game ends when all are matched.
REQ-002 Parameter HIDE_CYCLES, default 50_000_000: cycles that mismatched cards stay visible before hide_req.
REQ-003 Parameter TIMEOUT_CYCLES, default 500_000_000: per-turn time limit; used only with TURN_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all flops rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level; begins a game from IDLE or GAME_OVER.
REQ-007 turn_done  input  2  turn-result code from the turn/compare block: 2'b01 = second card selected; other values = no event.
REQ-008 match  input  1  valid in the cycle turn_done==2'b01; 1 means the two cards are equal.
REQ-009 score_j1  input  8  unsigned score of player 0.
REQ-010 score_j2  input  8  unsigned score of player 1.
REQ-011 player  output  1  current player (0 = J1, 1 = J2); drives the turn/compare block.
REQ-012 busy  output  1  high while the block is not accepting selections (SHOW, SWITCH, IDLE, GAME_OVER).
REQ-013 hide_req  output  1  one-cycle pulse that tells the board to flip the mismatched pair back.
REQ-014 pairs_found  output  8  number of matched pairs in the current game.
REQ-015 game_over  output  1  level; high in GAME_OVER.
REQ-016 winner  output  2  valid when game_over: 2'b01 = J1, 2'b10 = J2, 2'b11 = tie.

Function
REQ-017 FSM states: IDLE, WAIT_TURN, SHOW, SWITCH, GAME_OVER.
REQ-018 IDLE: start=1 -> WAIT_TURN next cycle; clears player, pairs_found and timers.
REQ-019 WAIT_TURN, turn_done==2'b01 and match=1: increment pairs_found; player unchanged.
- If the new pairs_found equals NUM_PAIRS -> GAME_OVER.
- Otherwise remain in WAIT_TURN; the turn timer restarts.
REQ-020 WAIT_TURN, turn_done==2'b01 and match=0 -> SHOW; hide counter loads 0.
REQ-021 SHOW: count to HIDE_CYCLES-1, then assert hide_req for exactly one cycle -> SWITCH.
REQ-022 SWITCH: toggle player -> WAIT_TURN; this state lasts one cycle.
REQ-023 turn_done events outside WAIT_TURN are ignored; they change no counter or state.
REQ-024 winner is computed combinationally from score_j1 vs score_j2, and is registered on entry to GAME_OVER.
REQ-025 GAME_OVER holds all outputs until start=1; start=1 behaves as in IDLE (a new game).
REQ-026 pairs_found saturates at NUM_PAIRS and never wraps.
REQ-027 Latency: player toggles HIDE_CYCLES+2 cycles after a mismatching turn_done.

Reset
REQ-028 rst=1 immediately forces: state IDLE, player=0, busy=1, hide_req=0, pairs_found=0, game_over=0, winner=2'b00, all counters 0.
REQ-029 Reset asserted mid-SHOW discards the pending hide_req; no pulse is produced after reset releases.

Configuration
REQ-030 Macro TURN_TIMEOUT_EN defined: a turn timer counts in WAIT_TURN and restarts on any turn_done==2'b01.
- When the timer reaches TIMEOUT_CYCLES-1 with no event -> SWITCH; no hide_req is issued.
- If turn_done==2'b01 arrives in that same cycle, the event wins and the timeout is discarded.
REQ-031 TURN_TIMEOUT_EN undefined: no turn timer flops exist; WAIT_TURN waits indefinitely.

Structure
REQ-032 Shared package memo_pkg holds:
- the FSM state enum;
- turn-code constants TURN_NONE=2'b00 and TURN_DONE=2'b01;
- winner code constants.
REQ-033 Sub-module delay_cnt: a loadable up-counter with terminal-count pulse, instantiated for the hide timer and the turn timer.

Verification
REQ-034 Reset, then start, then 8 matching turn_done pulses (NUM_PAIRS=8) -> pairs_found=8, game_over=1, player=0 throughout.
REQ-035 HIDE_CYCLES=4, one mismatch turn_done -> hide_req high exactly on cycle 5 after the event, player=1 on cycle 6.
REQ-036 End scores 3/5 -> winner=2'b10; end scores 4/4 -> winner=2'b11.
REQ-037 turn_done pulse during SHOW -> pairs_found unchanged, only one player toggle.
REQ-038 rst pulsed 2 cycles into SHOW -> all outputs at reset values, no hide_req afterwards.
REQ-039 TURN_TIMEOUT_EN, TIMEOUT_CYCLES=10, no events -> player toggles every 11 cycles and hide_req stays 0.
